hazard_control_unit: RTL
========================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter MMIO_TIMEOUT, default 64, range 1..255: maximum number of WAIT cycles before an MMIO access is abandoned.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ID_RS1 / ID_RS2  input  5 each  decode-stage source register addresses.
REQ-005 SHALL have ID_USES_RS1 / ID_USES_RS2  input  1 each  decode instruction actually reads that source.
REQ-006 SHALL have ID_BRANCH / ID_JUMPR  input  1 each  decode instruction is a conditional branch / JALR.
REQ-007 SHALL have ID_TAKEN  input  1  decode stage redirects the PC (taken branch, JAL, JALR).
REQ-008 SHALL have ID_EX_RD  input  5  ID/EX destination register.
REQ-009 SHALL have ID_EX_REG_WRITE / ID_EX_MEM_READ  input  1 each  ID/EX write-back enable / load flag.
REQ-010 SHALL have EX_MEM_RD  input  5  EX/MEM destination register.
REQ-011 SHALL have EX_MEM_MEM_READ  input  1  EX/MEM instruction is a load.
REQ-012 SHALL have EX_MEM_MMIO  input  1  EX/MEM instruction is a load or store to the multi-cycle MMIO (image coprocessor) region.
REQ-013 SHALL have MMIO_ACK  input  1  MMIO access complete.
REQ-014 SHALL have PERF_CLR  input  1  clears STALL_CYCLES.
REQ-015 SHALL have PC_STALL / IF_ID_STALL  output  1 each  hold the PC / the IF/ID register.
REQ-016 SHALL have PIPE_FREEZE  output  1  hold the ID/EX, EX/MEM and MEM/WB registers.
REQ-017 SHALL have IF_ID_FLUSH / ID_EX_FLUSH  output  1 each  insert a bubble into IF/ID / ID/EX.
REQ-018 SHALL have MMIO_REQ  output  1  single-cycle MMIO start pulse.
REQ-019 SHALL have MMIO_ERR  output  1  sticky MMIO timeout flag.
REQ-020 SHALL have STALL_CYCLES  output  32  performance counter of stalled cycles.

Function
REQ-021 SHALL define match(r) = (r!=0) & ((ID_USES_RS1 & r==ID_RS1) | (ID_USES_RS2 & r==ID_RS2)).
REQ-022 SHALL detect load-use = ID_EX_MEM_READ & match(ID_EX_RD).
REQ-023 SHALL detect branch hazard = (ID_BRANCH|ID_JUMPR) & ((ID_EX_REG_WRITE & match(ID_EX_RD)) | (EX_MEM_MEM_READ & match(EX_MEM_RD))). As the load advances, a load followed by a dependent branch therefore stalls exactly 2 cycles.
REQ-024 SHALL, on a hazard with no freeze: PC_STALL=IF_ID_STALL=ID_EX_FLUSH=1, IF_ID_FLUSH=0. Stall outputs are combinational and apply in the same cycle.
REQ-025 SHALL assert IF_ID_FLUSH = ID_TAKEN & ~hazard & ~freeze. A stall suppresses the redirect flush because the branch operands are stale.
REQ-026 SHALL run an FSM with states IDLE and WAIT and an 8-bit wait counter.
REQ-027 IDLE & EX_MEM_MMIO: MMIO_REQ=1, freeze=1, next state WAIT, counter cleared to 0. MMIO_ACK is ignored in IDLE.
REQ-028 WAIT & MMIO_ACK: freeze=0, next state IDLE. The pipeline advances at this edge, so the same access is not re-requested.
REQ-029 WAIT & ~MMIO_ACK & counter==MMIO_TIMEOUT-1: set MMIO_ERR, freeze=0, next state IDLE.
REQ-030 WAIT, other cycles: freeze=1, counter increments by 1.
REQ-031 Freeze (highest priority): PC_STALL=IF_ID_STALL=PIPE_FREEZE=1, both flushes=0. Hazards are re-evaluated after release.
REQ-032 STALL_CYCLES SHALL increment by 1 (wrapping at 2^32) in every cycle PC_STALL=1. PERF_CLR forces 0 and wins over a simultaneous increment.
REQ-033 Back-to-back MMIO accesses SHALL each get their own MMIO_REQ; the second request is issued in the IDLE cycle after release.

Reset
REQ-034 rst SHALL force: state IDLE, counter 0, MMIO_ERR=0, STALL_CYCLES=0, MMIO_REQ=0. Only MMIO_REQ is gated by reset; the combinational stall/flush outputs are still driven from the inputs.
REQ-035 Reset during WAIT SHALL abandon the access with no ERR; MMIO_ERR is cleared only by rst.

Structure
REQ-036 The FSM state enum and the WAIT-counter width constant SHALL live in common_params. MMIO_TIMEOUT remains a module parameter.
REQ-037 The block SHALL be a single module with no sub-modules; it sits upstream of FORWARDING_UNIT, sharing its pipeline-register inputs.

Verification
REQ-038 ID_EX lw x5; ID add reading x5 with USES_RS1=1 -> exactly 1 cycle of PC_STALL/ID_EX_FLUSH; STALL_CYCLES=1.
REQ-039 lw x7 then beq x7,x0 taken -> 2 stall cycles, then IF_ID_FLUSH for 1 cycle; STALL_CYCLES=2.
REQ-040 ID_EX_RD=0 with load flag, or USES_RS2=0 while RS2 matches -> no stall.
REQ-041 MMIO store, ACK after 3 WAIT cycles -> MMIO_REQ pulse, freeze for 4 cycles, MMIO_ERR=0.
REQ-042 MMIO_TIMEOUT=4 with ACK never asserted -> release after 4 WAIT cycles, MMIO_ERR=1 until rst; a taken branch during freeze produces no flush.
REQ-043 PERF_CLR asserted on a stall cycle -> STALL_CYCLES=0 next cycle; rst mid-WAIT -> IDLE, no ERR.

Source files
------------

// File: rtl/common_params.sv
// Shared constants and types for the hazard/MMIO control path.
package common_params;

    localparam int WAIT_CNT_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mmio_state_e;

endpackage

// File: rtl/hazard_control_unit.sv
// Pipeline hazard detection, stall/flush generation, MMIO wait-state FSM and
// stalled-cycle performance counter.
module hazard_control_unit
    import common_params::*;
#(
    parameter int unsigned MMIO_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_RS1,
    input  logic [4:0]  ID_RS2,
    input  logic        ID_USES_RS1,
    input  logic        ID_USES_RS2,
    input  logic        ID_BRANCH,
    input  logic        ID_JUMPR,
    input  logic        ID_TAKEN,
    input  logic [4:0]  ID_EX_RD,
    input  logic        ID_EX_REG_WRITE,
    input  logic        ID_EX_MEM_READ,
    input  logic [4:0]  EX_MEM_RD,
    input  logic        EX_MEM_MEM_READ,
    input  logic        EX_MEM_MMIO,
    input  logic        MMIO_ACK,
    input  logic        PERF_CLR,
    output logic        PC_STALL,
    output logic        IF_ID_STALL,
    output logic        PIPE_FREEZE,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_FLUSH,
    output logic        MMIO_REQ,
    output logic        MMIO_ERR,
    output logic [31:0] STALL_CYCLES
);

    localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(MMIO_TIMEOUT - 1);

    mmio_state_e           state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [31:0]           stall_q, stall_d;

    logic freeze;
    logic req;
    logic hazard;
    logic load_use;
    logic branch_haz;

    // A register 0 destination never creates a dependency.
    function automatic logic src_match(input logic [4:0] r,
                                       input logic [4:0] rs1, input logic u1,
                                       input logic [4:0] rs2, input logic u2);
        return (r != 5'd0) && ((u1 && (r == rs1)) || (u2 && (r == rs2)));
    endfunction

    always_comb begin
        load_use   = ID_EX_MEM_READ &&
                     src_match(ID_EX_RD, ID_RS1, ID_USES_RS1, ID_RS2, ID_USES_RS2);
        branch_haz = (ID_BRANCH || ID_JUMPR) &&
                     ((ID_EX_REG_WRITE &&
                       src_match(ID_EX_RD, ID_RS1, ID_USES_RS1, ID_RS2, ID_USES_RS2)) ||
                      (EX_MEM_MEM_READ &&
                       src_match(EX_MEM_RD, ID_RS1, ID_USES_RS1, ID_RS2, ID_USES_RS2)));
        hazard     = load_use || branch_haz;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        freeze  = 1'b0;
        req     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (EX_MEM_MMIO) begin
                    req     = 1'b1;
                    freeze  = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                // Releasing lets the pipeline advance, so the access is not re-issued.
                if (MMIO_ACK) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    freeze  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Freeze dominates; a stalled redirect is dropped because its operands are stale.
    always_comb begin
        PC_STALL    = freeze || hazard;
        IF_ID_STALL = freeze || hazard;
        PIPE_FREEZE = freeze;
        ID_EX_FLUSH = hazard && !freeze;
        IF_ID_FLUSH = ID_TAKEN && !hazard && !freeze;
        MMIO_REQ    = req && !rst;
        MMIO_ERR    = err_q;
        STALL_CYCLES = stall_q;
    end

    always_comb begin
        stall_d = stall_q;
        if (PERF_CLR) begin
            stall_d = '0;
        end else if (PC_STALL) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

endmodule
